// File: rtl/resta_ctrl_if.sv
// Purpose : switch/button/subtractor bundle between the operand-capture stage and its environment.
// Ports   : sw, btn, R_in, C_in flow into the stage; A_out, B_out, R_q, C_q/N_q/V_q/Z_q, done, state_q flow out.
// Modports: slave = the capture stage, master = the board/testbench side driving switches and the subtractor.
interface resta_ctrl_if #(
  parameter int M = 4
);
  logic [M-1:0] sw;
  logic         btn;
  logic [M-1:0] R_in;
  logic         C_in;
  logic [M-1:0] A_out;
  logic [M-1:0] B_out;
  logic [M-1:0] R_q;
  logic         C_q;
  logic         N_q;
  logic         V_q;
  logic         Z_q;
  logic         done;
  logic [1:0]   state_q;

  modport slave (
    input  sw, btn, R_in, C_in,
    output A_out, B_out, R_q, C_q, N_q, V_q, Z_q, done, state_q
  );

  modport master (
    output sw, btn, R_in, C_in,
    input  A_out, B_out, R_q, C_q, N_q, V_q, Z_q, done, state_q
  );
endinterface

// File: rtl/resta_ctrl.sv
// Purpose : captures A then B from the switch bus on button presses, then registers the subtractor result and N/V/Z/C flags.
// Latency : A_out/B_out valid the edge the press is sampled; result and done valid one edge after the B capture (single CALC cycle).
// Backpressure: none; presses in CALC are dropped, a held button yields one press, results hold until the next A capture.
// Ports   : clk, rst (sync, active high); bus (resta_ctrl_if.slave) carries sw, btn, R_in, C_in in and A_out, B_out,
//           R_q, C_q, N_q, V_q, Z_q, done, state_q out.
module resta_ctrl #(
  parameter int M = 4
) (
  input  logic        clk,
  input  logic        rst,
  resta_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    CALC   = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         btn_prev_q;
  logic [M-1:0] a_q, a_d;
  logic [M-1:0] b_q, b_d;
  logic [M-1:0] r_q, r_d;
  logic         c_q, c_d;
  logic         n_q, n_d;
  logic         v_q, v_d;
  logic         z_q, z_d;
  logic         done_q, done_d;
  logic         press;

  // Rising edge of the (already synchronised) button level.
  assign press = bus.btn & ~btn_prev_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    done_d  = done_q;
    unique case (state_q)
      WAIT_A: begin
        if (press) begin
          a_d     = bus.sw;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (press) begin
          b_d     = bus.sw;
          state_d = CALC;
        end
      end
      CALC: begin
        // R_in is a combinational function of a_q/b_q, so it is settled here.
        r_d     = bus.R_in;
        c_d     = bus.C_in;
        n_d     = bus.R_in[M-1];
        z_d     = (bus.R_in == '0);
        // Subtraction overflows only when operand signs differ and the
        // result sign disagrees with the minuend.
        v_d     = (a_q[M-1] != b_q[M-1]) & (bus.R_in[M-1] != a_q[M-1]);
        done_d  = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        // Start the next operation directly; this edge captures A.
        if (press) begin
          a_d     = bus.sw;
          done_d  = 1'b0;
          state_d = WAIT_B;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= WAIT_A;
      // Treat the button as already pressed so a level held through reset does not fire.
      btn_prev_q <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      c_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      z_q        <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= bus.btn;
      a_q        <= a_d;
      b_q        <= b_d;
      r_q        <= r_d;
      c_q        <= c_d;
      n_q        <= n_d;
      v_q        <= v_d;
      z_q        <= z_d;
      done_q     <= done_d;
    end
  end

  assign bus.A_out   = a_q;
  assign bus.B_out   = b_q;
  assign bus.R_q     = r_q;
  assign bus.C_q     = c_q;
  assign bus.N_q     = n_q;
  assign bus.V_q     = v_q;
  assign bus.Z_q     = z_q;
  assign bus.done    = done_q;
  assign bus.state_q = state_q;

endmodule

// File: tb/tb_resta_ctrl.sv
module tb_resta_ctrl;
  localparam int M = 4;

  typedef struct {
    logic [M-1:0] r;
    logic [3:0]   cnvz;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  resta_ctrl_if #(.M(M)) bus ();

  resta_ctrl #(.M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Subtractor model feeding the stage.
  assign bus.R_in = bus.A_out - bus.B_out;
  assign bus.C_in = (bus.A_out >= bus.B_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [M-1:0] v);
    bus.sw  = v;
    bus.btn = 1'b1;
    @(negedge clk);
    bus.btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [M-1:0] r, input logic [3:0] cnvz);
    exp_t e;
    e.r    = r;
    e.cnvz = cnvz;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [M-1:0] a, input logic [M-1:0] b,
                    input logic [M-1:0] r, input logic [3:0] cnvz);
    push(r, cnvz);
    press(a);
    chk("A capture", 32'(bus.A_out), 32'(a));
    press(b);
    chk("state after B press", 32'(bus.state_q), 32'd3);
    chk("done after B press", 32'(bus.done), 32'd1);
  endtask

  // Monitor: a rising done marks a new result; compare it with the oldest expectation.
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected result", 32'(bus.R_q), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("result R", 32'(bus.R_q), 32'(e.r));
          chk("flags CNVZ", 32'({bus.C_q, bus.N_q, bus.V_q, bus.Z_q}), 32'(e.cnvz));
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.btn = 1'b1;
    bus.sw  = 4'h5;
    cyc(3);
    rst = 1'b0;
    cyc(3);
    // Button held through reset release must not fire.
    chk("reset state", 32'(bus.state_q), 32'd0);
    chk("reset A/B/R", 32'({bus.A_out, bus.B_out, bus.R_q}), 32'd0);
    chk("reset flags/done", 32'({bus.C_q, bus.N_q, bus.V_q, bus.Z_q, bus.done}), 32'd0);
    bus.btn = 1'b0;
    cyc(1);

    // First operation: 6 - 6.
    op(4'h6, 4'h6, 4'h0, 4'b1001);
    // Back-to-back from HOLD.
    op(4'h7, 4'h3, 4'h4, 4'b1000);
    op(4'h3, 4'h5, 4'hE, 4'b0100);
    op(4'h5, 4'h5, 4'h0, 4'b1001);
    op(4'h7, 4'h8, 4'hF, 4'b0110);
    op(4'h8, 4'h1, 4'h7, 4'b1010);

    // Held button in WAIT_A: one capture only.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    bus.sw  = 4'hA;
    bus.btn = 1'b1;
    cyc(10);
    chk("held btn state", 32'(bus.state_q), 32'd1);
    chk("held btn A", 32'(bus.A_out), 32'hA);
    bus.btn = 1'b0;
    cyc(1);

    // Button held across B capture, CALC and into HOLD: no re-capture.
    push(4'h8, 4'b1100);
    bus.sw  = 4'h2;
    bus.btn = 1'b1;
    cyc(5);
    chk("held through CALC state", 32'(bus.state_q), 32'd3);
    chk("held through CALC A", 32'(bus.A_out), 32'hA);
    chk("held through CALC B", 32'(bus.B_out), 32'h2);
    bus.btn = 1'b0;
    cyc(1);

    // HOLD restart.
    press(4'h9);
    chk("restart A", 32'(bus.A_out), 32'h9);
    chk("restart done", 32'(bus.done), 32'd0);
    chk("restart state", 32'(bus.state_q), 32'd1);
    chk("restart R retained", 32'(bus.R_q), 32'h8);
    chk("restart B retained", 32'(bus.B_out), 32'h2);

    // Reset in WAIT_B, with a press in the same cycle.
    rst     = 1'b1;
    bus.sw  = 4'h3;
    bus.btn = 1'b1;
    cyc(1);
    chk("midop reset state", 32'(bus.state_q), 32'd0);
    chk("midop reset A/B/R", 32'({bus.A_out, bus.B_out, bus.R_q}), 32'd0);
    chk("midop reset flags/done", 32'({bus.C_q, bus.N_q, bus.V_q, bus.Z_q, bus.done}), 32'd0);
    rst     = 1'b0;
    bus.btn = 1'b0;
    cyc(3);
    chk("pending expectations", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
